base_rr_enc_arb: RTL and testbench
==================================

BASE_RR_ENC_ARB -- requirements
Module: base_rr_enc_arb

Interface
REQ-001 SHALL have parameter: ways, 2, number of requesting ways; legal range 2..64.
REQ-002 SHALL have parameter: sel_width, $clog2(ways), width of the encoded select.
REQ-003 SHALL have port: clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port: reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: i_v  input  ways  per-way request valid; bit 0 = way 0.
REQ-006 SHALL have port: i_r  output  ways  per-way grant-accept pulse, one-hot or zero.
REQ-007 SHALL have port: o_v  output  1  registered grant valid to the downstream encoded mux stage.
REQ-008 SHALL have port: o_r  input  1  downstream ready; grant consumed when o_v & o_r.
REQ-009 SHALL have port: o_sel  output  sel_width  registered encoded index of the granted way; drives the downstream mux select directly.

Function
REQ-010 SHALL hold one grant register (o_v, o_sel) and a last-grant pointer ptr of sel_width bits.
REQ-011 SHALL define load = (~o_v | o_r) & (|i_v), evaluated combinationally each cycle.
REQ-012 SHALL choose the winner as the first way with i_v set, searching ptr+1, ptr+2, ... with wrap from ways-1 to 0; ptr itself is searched last.
REQ-013 SHALL wrap modulo ways, not modulo 2^sel_width, for non-power-of-2 ways; indices >= ways never appear on o_sel.
REQ-014 SHALL, on a load cycle, assert i_r[winner] only, then at the clock edge set o_v=1, o_sel=winner, ptr=winner.
REQ-015 SHALL keep i_r all zero on every non-load cycle.
REQ-016 SHALL, when o_v & o_r and no i_v bit is set, clear o_v at the edge; o_sel and ptr are held.
REQ-017 SHALL, when o_v & ~o_r, hold o_sel, o_v and ptr unchanged; i_r stays zero (stall).
REQ-018 SHALL have a latency of 1 cycle from request to o_v, and sustain one grant per cycle while o_r=1.
REQ-019 SHALL NOT require a requester to hold i_v after i_r; a dropped i_v before grant is simply not selected.
REQ-020 SHALL remain fair: a continuously requesting way is granted within ways consecutive loads.

Reset
REQ-021 SHALL, with reset_n low, force asynchronously: o_v=0, o_sel=0, ptr=ways-1 (first search starts at way 0), lock state cleared.
REQ-022 SHALL drive i_r=0 during reset.
REQ-023 SHALL discard any pending grant on reset mid-operation; no grant is replayed after release.
REQ-024 SHALL allow loads from the first rising clk edge after reset_n deasserts.

Configuration
REQ-025 SHALL compile a lock feature in only when the macro BASE_RR_ENC_ARB_LOCK_EN is defined.
REQ-026 SHALL, with the macro defined, add port: i_lock  input  1  sampled on load cycles.
REQ-027 SHALL, with the macro defined, enter the locked state when loading with i_lock=1; while locked, only way ptr may win, and other ways are ignored.
REQ-028 SHALL, with the macro defined, leave the locked state on a load with i_lock=0; if way ptr is idle while locked, load stays low.
REQ-029 SHALL, without the macro, have no i_lock port and no lock state; behaviour per REQ-010..REQ-020.

Verification (ways=4)
REQ-030 SHALL cover: reset, i_v=1111, o_r=1 held -> o_v=1 from cycle 1; o_sel=0,1,2,3,0 on consecutive cycles; i_r one-hot matching each grant.
REQ-031 SHALL cover: grant o_sel=2 pending, o_r=0 for 3 cycles with i_v=1111 -> o_sel stays 2, i_r=0000; on o_r=1 next o_sel=3.
REQ-032 SHALL cover: last grant 3, i_v={way1,way3} -> next o_sel=1 (wrap), then 3, then 1.
REQ-033 SHALL cover: ways=3, all request, o_r=1 -> o_sel sequence 0,1,2,0; value 3 never appears.
REQ-034 SHALL cover: o_v=1, o_sel=2, reset_n pulsed low mid-cycle -> o_v=0 immediately; after release with i_v=1111 first o_sel=0.
REQ-035 SHALL cover, with BASE_RR_ENC_ARB_LOCK_EN: way1 granted with i_lock=1, i_v=1111 -> o_sel=1 repeatedly; a load with i_lock=0 -> next o_sel=2.

Source files
------------

// File: rtl/base_rr_enc_arb.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// base_rr_enc_arb
//
// Round-robin arbiter with a registered, binary-encoded grant. Every grant
// goes out as an index (o_sel) plus a valid (o_v). The index drives a
// downstream mux select directly. A requester learns that it won from a
// one-cycle accept pulse on i_r.
//
// Parameters
//   ways       number of requesting ways (2..64)
//   sel_width  width of the encoded select, $clog2(ways)
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   i_v      per-way request valid, bit 0 = way 0
//   i_r      per-way accept pulse, one-hot on a load cycle, zero otherwise
//   o_v      registered grant valid
//   o_r      downstream ready; the grant is consumed when o_v & o_r
//   o_sel    registered index of the granted way
//   i_lock   (only with BASE_RR_ENC_ARB_LOCK_EN) lock request, sampled on loads
//
// Optional feature macro: BASE_RR_ENC_ARB_LOCK_EN
//   When this macro is defined, a load taken with i_lock=1 pins the arbiter
//   to the way just granted. While pinned, only that way can win. A load
//   taken with i_lock=0 releases the pin.
// ---------------------------------------------------------------------------
module base_rr_enc_arb #(
    parameter int ways      = 2,
    parameter int sel_width = $clog2(ways)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ways-1:0]      i_v,
    output logic [ways-1:0]      i_r,
`ifdef BASE_RR_ENC_ARB_LOCK_EN
    input  logic                 i_lock,
`endif
    output logic                 o_v,
    input  logic                 o_r,
    output logic [sel_width-1:0] o_sel
);

    logic [sel_width-1:0] ptr;
    logic [ways-1:0]      req_rot;
    logic [sel_width-1:0] rr_win;
    logic                 rr_any;
    logic [sel_width-1:0] win;
    logic                 any;
    logic                 load;

    // Round-robin search. The request vector is rotated so that bit 0 holds
    // way ptr+1. Shifting a doubled copy makes the wrap happen at ways, not
    // at 2^sel_width. The lowest set bit gives the offset of the winner.
    always_comb begin
        int off;
        int idx;
        req_rot = ways'({i_v, i_v} >> (int'(ptr) + 1));
        off     = 0;
        for (int k = ways - 1; k >= 0; k--) begin
            if (req_rot[k]) off = k;
        end
        idx = int'(ptr) + 1 + off;
        if (idx >= ways) idx = idx - ways;
        rr_win = sel_width'(idx);
        rr_any = |i_v;
    end

`ifdef BASE_RR_ENC_ARB_LOCK_EN
    logic locked;

    // While locked, only the last-granted way is eligible. If that way is
    // idle, nothing loads.
    always_comb begin
        win = locked ? ptr : rr_win;
        any = locked ? i_v[ptr] : rr_any;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked <= 1'b0;
        end else if (load) begin
            locked <= i_lock;
        end
    end
`else
    assign win = rr_win;
    assign any = rr_any;
`endif

    // Gating with reset_n keeps i_r quiet while reset is held.
    assign load = reset_n & (~o_v | o_r) & any;

    always_comb begin
        i_r = '0;
        if (load) i_r[win] = 1'b1;
    end

    // Grant register. A load replaces the grant. A consumed grant with no
    // replacement drops o_v and leaves o_sel/ptr as they were. A stall holds
    // everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_v   <= 1'b0;
            o_sel <= '0;
            ptr   <= sel_width'(ways - 1);
        end else if (load) begin
            o_v   <= 1'b1;
            o_sel <= win;
            ptr   <= win;
        end else if (o_r) begin
            o_v   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_base_rr_enc_arb.sv
`timescale 1ns/1ps
module tb_base_rr_enc_arb;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] v4, ir4;
    logic       or4, ov4;
    logic [1:0] sel4;
    logic [2:0] v3, ir3;
    logic       or3, ov3;
    logic [1:0] sel3;
`ifdef BASE_RR_ENC_ARB_LOCK_EN
    logic       lk4, lk3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    base_rr_enc_arb #(.ways(4)) u_arb4 (
        .clk(clk), .reset_n(reset_n), .i_v(v4), .i_r(ir4),
`ifdef BASE_RR_ENC_ARB_LOCK_EN
        .i_lock(lk4),
`endif
        .o_v(ov4), .o_r(or4), .o_sel(sel4)
    );

    base_rr_enc_arb #(.ways(3)) u_arb3 (
        .clk(clk), .reset_n(reset_n), .i_v(v3), .i_r(ir3),
`ifdef BASE_RR_ENC_ARB_LOCK_EN
        .i_lock(lk3),
`endif
        .o_v(ov3), .o_r(or3), .o_sel(sel3)
    );

    // Reference rule: the first requesting way after ptr, modulo n.
    // Returns -1 when no way is requesting.
    function automatic int rr_pick(int ptr, int iv, int n);
        for (int k = 1; k <= n; k++) begin
            int c;
            c = (ptr + k) % n;
            if (((iv >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    task automatic apply_reset();
        reset_n = 1'b0;
        v4 = '0; or4 = 1'b0; v3 = '0; or3 = 1'b0;
`ifdef BASE_RR_ENC_ARB_LOCK_EN
        lk4 = 1'b0; lk3 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        v4 = 4'b1111; or4 = 1'b1; v3 = 3'b111; or3 = 1'b1;
`ifdef BASE_RR_ENC_ARB_LOCK_EN
        lk4 = 1'b0; lk3 = 1'b0;
`endif
        @(posedge clk); #1;
        n_checks++;
        if ({ov4, sel4} !== 3'b000) begin
            n_fail++; $display("FAIL reset_out4 got=%b exp=000", {ov4, sel4});
        end
        n_checks++;
        if (ir4 !== 4'b0000) begin
            n_fail++; $display("FAIL reset_ir4 got=%b exp=0000", ir4);
        end
        n_checks++;
        if ({ov3, sel3} !== 3'b000) begin
            n_fail++; $display("FAIL reset_out3 got=%b exp=000", {ov3, sel3});
        end
        n_checks++;
        if (ir3 !== 3'b000) begin
            n_fail++; $display("FAIL reset_ir3 got=%b exp=000", ir3);
        end
        #1 reset_n = 1'b1;
        v4 = '0; v3 = '0;
        @(posedge clk); #1;
        n_checks++;
        if (ov4 !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset got=%b exp=0", ov4);
        end
    endtask

    task automatic test_all_req();
        int seq[5] = '{0, 1, 2, 3, 0};
        apply_reset();
        v4 = 4'b1111; or4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #3;
            n_checks++;
            if (ir4 !== 4'(1 << seq[i])) begin
                n_fail++; $display("FAIL all_req_ir step=%0d got=%b exp=%b", i, ir4, 4'(1 << seq[i]));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov4, sel4} !== {1'b1, 2'(seq[i])}) begin
                n_fail++; $display("FAIL all_req_sel step=%0d got=%b exp=%b", i, {ov4, sel4}, {1'b1, 2'(seq[i])});
            end
        end
    endtask

    task automatic test_stall();
        int seq[2] = '{1, 2};
        for (int i = 0; i < 2; i++) begin
            #3;
            n_checks++;
            if (ir4 !== 4'(1 << seq[i])) begin
                n_fail++; $display("FAIL stall_pre_ir step=%0d got=%b exp=%b", i, ir4, 4'(1 << seq[i]));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov4, sel4} !== {1'b1, 2'(seq[i])}) begin
                n_fail++; $display("FAIL stall_pre_sel step=%0d got=%b exp=%b", i, {ov4, sel4}, {1'b1, 2'(seq[i])});
            end
        end
        or4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (ir4 !== 4'b0000) begin
                n_fail++; $display("FAIL stall_ir cyc=%0d got=%b exp=0000", i, ir4);
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov4, sel4} !== 3'b110) begin
                n_fail++; $display("FAIL stall_hold cyc=%0d got=%b exp=110", i, {ov4, sel4});
            end
        end
        or4 = 1'b1;
        #3;
        n_checks++;
        if (ir4 !== 4'b1000) begin
            n_fail++; $display("FAIL stall_release_ir got=%b exp=1000", ir4);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ov4, sel4} !== 3'b111) begin
            n_fail++; $display("FAIL stall_release_sel got=%b exp=111", {ov4, sel4});
        end
    endtask

    task automatic test_wrap();
        int seq[3] = '{1, 3, 1};
        v4 = 4'b1010; or4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            n_checks++;
            if (ir4 !== 4'(1 << seq[i])) begin
                n_fail++; $display("FAIL wrap_ir step=%0d got=%b exp=%b", i, ir4, 4'(1 << seq[i]));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov4, sel4} !== {1'b1, 2'(seq[i])}) begin
                n_fail++; $display("FAIL wrap_sel step=%0d got=%b exp=%b", i, {ov4, sel4}, {1'b1, 2'(seq[i])});
            end
        end
    endtask

    task automatic test_reset_mid();
        v4 = 4'b1111; or4 = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({ov4, sel4} !== 3'b110) begin
            n_fail++; $display("FAIL mid_setup got=%b exp=110", {ov4, sel4});
        end
        or4 = 1'b0;
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({ov4, sel4} !== 3'b000) begin
            n_fail++; $display("FAIL mid_async_clear got=%b exp=000", {ov4, sel4});
        end
        n_checks++;
        if (ir4 !== 4'b0000) begin
            n_fail++; $display("FAIL mid_ir_in_reset got=%b exp=0000", ir4);
        end
        #2 reset_n = 1'b1;
        or4 = 1'b1;
        #1;
        n_checks++;
        if (ir4 !== 4'b0001) begin
            n_fail++; $display("FAIL mid_first_ir got=%b exp=0001", ir4);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({ov4, sel4} !== 3'b100) begin
            n_fail++; $display("FAIL mid_first_sel got=%b exp=100", {ov4, sel4});
        end
    endtask

    task automatic test_ways3();
        int seq[4] = '{0, 1, 2, 0};
        apply_reset();
        v3 = 3'b111; or3 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #3;
            n_checks++;
            if (ir3 !== 3'(1 << seq[i])) begin
                n_fail++; $display("FAIL ways3_ir step=%0d got=%b exp=%b", i, ir3, 3'(1 << seq[i]));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov3, sel3} !== {1'b1, 2'(seq[i])}) begin
                n_fail++; $display("FAIL ways3_sel step=%0d got=%b exp=%b", i, {ov3, sel3}, {1'b1, 2'(seq[i])});
            end
        end
    endtask

`ifdef BASE_RR_ENC_ARB_LOCK_EN
    task automatic test_lock();
        int tv[9]   = '{15, 15, 15, 15, 15, 15, 11, 15, 15};
        int tl[9]   = '{ 0,  1,  1,  1,  0,  1,  1,  0,  0};
        int tir[9]  = '{ 1,  2,  2,  2,  2,  4,  0,  4,  8};
        int tov[9]  = '{ 1,  1,  1,  1,  1,  1,  0,  1,  1};
        int tsel[9] = '{ 0,  1,  1,  1,  1,  2,  2,  2,  3};
        apply_reset();
        or4 = 1'b1;
        for (int i = 0; i < 9; i++) begin
            v4 = 4'(tv[i]); lk4 = (tl[i] != 0);
            #3;
            n_checks++;
            if (ir4 !== 4'(tir[i])) begin
                n_fail++; $display("FAIL lock_ir step=%0d got=%b exp=%b", i, ir4, 4'(tir[i]));
            end
            @(posedge clk); #1;
            n_checks++;
            if ({ov4, sel4} !== {1'(tov[i]), 2'(tsel[i])}) begin
                n_fail++; $display("FAIL lock_sel step=%0d got=%b exp=%b", i, {ov4, sel4}, {1'(tov[i]), 2'(tsel[i])});
            end
        end
        lk4 = 1'b0;
    endtask
`endif

    task automatic test_random();
        int n[2] = '{4, 3};
        int mv[2], ms[2], mp[2], ml[2];
        int iv[2], rdy[2], lk[2], ld[2], w[2];
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            mv[i] = 0; ms[i] = 0; mp[i] = n[i] - 1; ml[i] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            iv[0]  = int'($urandom_range(0, 15));
            iv[1]  = int'($urandom_range(0, 7));
            rdy[0] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            rdy[1] = ($urandom_range(0, 3) != 0) ? 1 : 0;
            lk[0]  = 0;
            lk[1]  = 0;
`ifdef BASE_RR_ENC_ARB_LOCK_EN
            lk[0]  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            lk4    = (lk[0] != 0);
`endif
            v4 = 4'(iv[0]); or4 = (rdy[0] != 0);
            v3 = 3'(iv[1]); or3 = (rdy[1] != 0);
            for (int i = 0; i < 2; i++) begin
                if (ml[i] != 0) begin
                    w[i]  = mp[i];
                    ld[i] = (((mv[i] == 0) || (rdy[i] != 0)) && (((iv[i] >> mp[i]) & 1) != 0)) ? 1 : 0;
                end else begin
                    w[i]  = rr_pick(mp[i], iv[i], n[i]);
                    ld[i] = (((mv[i] == 0) || (rdy[i] != 0)) && (w[i] >= 0)) ? 1 : 0;
                end
            end
            #3;
            n_checks++;
            if (ir4 !== ((ld[0] != 0) ? 4'(1 << w[0]) : 4'b0000)) begin
                n_fail++; $display("FAIL rand_ir4 cyc=%0d got=%b ld=%0d win=%0d", cyc, ir4, ld[0], w[0]);
            end
            n_checks++;
            if (ir3 !== ((ld[1] != 0) ? 3'(1 << w[1]) : 3'b000)) begin
                n_fail++; $display("FAIL rand_ir3 cyc=%0d got=%b ld=%0d win=%0d", cyc, ir3, ld[1], w[1]);
            end
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (ld[i] != 0) begin
                    mv[i] = 1; ms[i] = w[i]; mp[i] = w[i]; ml[i] = lk[i];
                end else if (rdy[i] != 0) begin
                    mv[i] = 0;
                end
            end
            n_checks++;
            if ({ov4, sel4} !== {(mv[0] != 0), 2'(ms[0])}) begin
                n_fail++; $display("FAIL rand_out4 cyc=%0d got=%b exp=%b", cyc, {ov4, sel4}, {(mv[0] != 0), 2'(ms[0])});
            end
            n_checks++;
            if ({ov3, sel3} !== {(mv[1] != 0), 2'(ms[1])}) begin
                n_fail++; $display("FAIL rand_out3 cyc=%0d got=%b exp=%b", cyc, {ov3, sel3}, {(mv[1] != 0), 2'(ms[1])});
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        v4 = '0; or4 = 1'b0; v3 = '0; or3 = 1'b0;
`ifdef BASE_RR_ENC_ARB_LOCK_EN
        lk4 = 1'b0; lk3 = 1'b0;
`endif
        test_reset();
        test_all_req();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_ways3();
`ifdef BASE_RR_ENC_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
